// File: rtl/row_uram_arbiter.sv
// row_uram_arbiter: round-robin arbiter sharing one URAM port among a row of cores, with a drain handshake per round
module row_uram_arbiter #(
  parameter int NUM_CORES       = 8,
  parameter int MAX_HOLD_CYCLES = 4096
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_CORES-1:0] i_core_req,
  input  logic [NUM_CORES-1:0] i_core_locked,
  input  logic [NUM_CORES-1:0] i_active_mask,
  input  logic                 i_drain_done,
  output logic [NUM_CORES-1:0] o_core_grant,
  output logic [NUM_CORES-1:0] o_uram_emptied,
  output logic                 o_drain_req,
  output logic                 o_hold_timeout
);
  localparam int PW = $clog2(NUM_CORES);
  localparam int CW = $clog2(MAX_HOLD_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, GRANT, DRAIN, EMPTIED} state_t;
  state_t               state, state_n;
  logic [NUM_CORES-1:0] served, served_n, eligible, rot, bit_g, grant_n, emptied_n;
  logic [PW-1:0]        rr_ptr, rr_n, g, g_n, sel;
  logic [PW:0]          off, sum;
  logic [CW-1:0]        cnt, cnt_n, cnt_inc;
  logic                 found, locked_seen, seen_n, drain_n, timeout_n, session_end, done_all;
  // rotate the eligible set so rr_ptr sits at bit 0, take the lowest set bit, then undo the rotation
  always_comb begin
    eligible = i_core_req & i_active_mask & ~served;
    rot      = NUM_CORES'({eligible, eligible} >> rr_ptr);
    off      = '0;
    found    = 1'b0;
    for (int i = NUM_CORES - 1; i >= 0; i--)
      if (rot[i]) begin
        off   = (PW+1)'(i);
        found = 1'b1;
      end
    sum = {1'b0, rr_ptr} + off;
    sel = (sum >= (PW+1)'(NUM_CORES)) ? PW'(sum - (PW+1)'(NUM_CORES)) : sum[PW-1:0];
  end
  // session tracking for the granted core: end of session, hold counter step, round completion
  always_comb begin
    bit_g       = NUM_CORES'(1) << g;
    cnt_inc     = (cnt == CW'(MAX_HOLD_CYCLES)) ? cnt : cnt + 1'b1;
    session_end = ~i_core_locked[g] & (locked_seen | ~i_core_req[g]);
    done_all    = (|i_active_mask) & ~|(i_active_mask & ~(served | bit_g));
  end
  // next state and next values of every registered output
  always_comb begin
    state_n   = state;
    served_n  = served;
    rr_n      = rr_ptr;
    g_n       = g;
    seen_n    = locked_seen;
    cnt_n     = cnt;
    grant_n   = '0;
    emptied_n = '0;
    drain_n   = 1'b0;
    timeout_n = o_hold_timeout;
    unique case (state)
      IDLE: if (found) begin
        state_n = GRANT;
        g_n     = sel;
        grant_n = NUM_CORES'(1) << sel;
      end
      GRANT: begin
        timeout_n = o_hold_timeout | (cnt_inc == CW'(MAX_HOLD_CYCLES));
        if (session_end) begin
          served_n = served | bit_g;
          rr_n     = (g == PW'(NUM_CORES - 1)) ? '0 : g + 1'b1;
          seen_n   = 1'b0;
          cnt_n    = '0;
          state_n  = done_all ? DRAIN : IDLE;
          drain_n  = done_all;
        end else begin
          grant_n = bit_g;
          seen_n  = locked_seen | i_core_locked[g];
          cnt_n   = cnt_inc;
        end
      end
      DRAIN: if (i_drain_done) begin
        state_n   = EMPTIED;
        emptied_n = '1;
        served_n  = '0;
      end else drain_n = 1'b1;
      EMPTIED: state_n = IDLE;
    endcase
  end
  // state and output registers; reset abandons any session or drain in progress
  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= IDLE;
      served         <= '0;
      rr_ptr         <= '0;
      g              <= '0;
      locked_seen    <= 1'b0;
      cnt            <= '0;
      o_core_grant   <= '0;
      o_uram_emptied <= '0;
      o_drain_req    <= 1'b0;
      o_hold_timeout <= 1'b0;
    end else begin
      state          <= state_n;
      served         <= served_n;
      rr_ptr         <= rr_n;
      g              <= g_n;
      locked_seen    <= seen_n;
      cnt            <= cnt_n;
      o_core_grant   <= grant_n;
      o_uram_emptied <= emptied_n;
      o_drain_req    <= drain_n;
      o_hold_timeout <= timeout_n;
    end
  end
endmodule

// File: tb/tb_row_uram_arbiter.sv
// tb_row_uram_arbiter: randomized scoreboard bench with a behavioural round model of the arbiter
module tb_row_uram_arbiter;
  localparam int N    = 4;
  localparam int MAXH = 16;
  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] req = '0, lk = '0, mask = '0;
  logic         dd = 1'b0;
  logic [N-1:0] o_core_grant, o_uram_emptied;
  logic         o_drain_req, o_hold_timeout;

  row_uram_arbiter #(.NUM_CORES(N), .MAX_HOLD_CYCLES(MAXH)) dut (
    .clk(clk), .reset(reset), .i_core_req(req), .i_core_locked(lk),
    .i_active_mask(mask), .i_drain_done(dd), .o_core_grant(o_core_grant),
    .o_uram_emptied(o_uram_emptied), .o_drain_req(o_drain_req), .o_hold_timeout(o_hold_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] g;
    logic [N-1:0] e;
    logic         d;
    logic         t;
  } exp_t;
  exp_t sbq[$];
  int tests = 0, fails = 0, cyc = 0;

  // reference model: who owns the port, which cores are done this round, and pending drain
  int           owner = -1, ptr = 0, hold = 0;
  bit           seen = 0, waiting = 0, emptied_now = 0, tmo = 0;
  logic [N-1:0] served = '0;

  function automatic void model_step(logic r, logic [N-1:0] rq, logic [N-1:0] l, logic [N-1:0] m, logic d);
    int c;
    if (!r) begin
      owner = -1; ptr = 0; hold = 0; seen = 0; waiting = 0; emptied_now = 0; tmo = 0; served = '0;
      return;
    end
    if (emptied_now) emptied_now = 0;
    else if (waiting) begin
      if (d) begin
        waiting = 0; emptied_now = 1; served = '0;
      end
    end else if (owner >= 0) begin
      hold++;
      if (hold >= MAXH) tmo = 1;
      if ((seen && !l[owner]) || (!rq[owner] && !l[owner])) begin
        served[owner] = 1'b1;
        ptr = (owner + 1) % N;
        owner = -1; hold = 0; seen = 0;
        waiting = (m != 0) && ((m & ~served) == 0);
      end else if (l[owner]) seen = 1;
    end else begin
      for (int k = 0; k < N; k++) begin
        c = (ptr + k) % N;
        if (rq[c] && m[c] && !served[c]) begin
          owner = c;
          break;
        end
      end
    end
  endfunction

  task automatic drive(input logic r, input logic [N-1:0] rq, input logic [N-1:0] l,
                       input logic [N-1:0] m, input logic d);
    exp_t e;
    @(negedge clk);
    reset = r; req = rq; lk = l; mask = m; dd = d;
    model_step(r, rq, l, m, d);
    e.g = (owner >= 0) ? (N'(1) << owner) : '0;
    e.e = emptied_now ? '1 : '0;
    e.d = waiting;
    e.t = tmo;
    sbq.push_back(e);
  endtask

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %b, expected %b", name, cyc, act, exp);
    end
  endtask

  // monitor: every cycle the DUT presents outputs, compare against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check("grant", o_core_grant, e.g);
        check("emptied", o_uram_emptied, e.e);
        check("drain_req", N'(o_drain_req), N'(e.d));
        check("hold_timeout", N'(o_hold_timeout), N'(e.t));
      end
    end
  end

  // core behaviour: the granted core follows a plan picked at grant time, others request at random
  logic [N-1:0] want = '0;
  int pmode = 0, pd = 0, pl = 0;

  task automatic run(input int cycles, input logic [N-1:0] m, input int want_pct,
                     input int force_mode, input int early_dd_pct, input int rst_pmil);
    logic [N-1:0] rq, l;
    logic d, r;
    int t;
    for (int i = 0; i < cycles; i++) begin
      rq = '0;
      l  = '0;
      for (int c = 0; c < N; c++) begin
        if (c == owner) continue;
        if (!want[c] && $urandom_range(0, 99) < want_pct) want[c] = 1'b1;
        rq[c] = want[c];
        l[c]  = ($urandom_range(0, 7) == 0);
      end
      if (owner >= 0) begin
        if (hold == 0) begin
          pmode = (force_mode >= 0) ? force_mode : (($urandom_range(0, 9) == 0) ? 2 : int'($urandom_range(0, 1)));
          pd    = $urandom_range(0, 3);
          pl    = (pmode == 2) ? $urandom_range(14, 20) : $urandom_range(1, 6);
          want[owner] = 1'b0;
        end
        t = hold;
        if (pmode == 0) begin
          rq[owner] = (t < pd);
          l[owner]  = 1'b0;
        end else begin
          l[owner]  = (t >= pd) && (t < pd + pl);
          rq[owner] = (t < pd + pl) ? 1'b1 : 1'($urandom_range(0, 1));
        end
      end
      d = waiting ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 99) < early_dd_pct);
      r = !($urandom_range(0, 999) < rst_pmil);
      drive(r, rq, l, m, d);
    end
  endtask

  initial begin
    int k;
    repeat (3) drive(1'b0, '0, '0, '0, 1'b0);
    want = '1;
    run(120, 4'b1111, 0, 1, 0, 0);
    want = 4'b0100;
    run(30, 4'b0101, 0, 1, 25, 0);
    want[0] = 1'b1;
    run(40, 4'b0101, 0, 1, 25, 0);
    want = 4'b0010;
    run(60, 4'b1111, 10, 2, 0, 0);
    want = '1;
    k = 0;
    while (k < 400 && !(owner == 3 && hold == 4)) begin
      run(1, 4'b1111, 30, 2, 0, 0);
      k++;
    end
    tests++;
    if (k == 400) begin
      fails++;
      $display("FAIL reach_core3_locked: got no lock within %0d cycles, expected core3 granted and locked", k);
    end
    drive(1'b0, '1, '1, '1, 1'b1);
    run(60, 4'b1111, 30, -1, 5, 0);
    run(60, 4'b1111, 50, 0, 0, 0);
    run(40, 4'b0000, 50, -1, 10, 0);
    for (int p = 0; p < 20; p++)
      run(150, 4'($urandom_range(0, 15)), $urandom_range(5, 60), -1, 5, 3);
    drive(1'b1, '0, '0, 4'b1111, 1'b0);
    @(posedge clk);
    #2;
    tests++;
    if (sbq.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/row_uram_arbiter.md
ROW_URAM_ARBITER -- requirements
Module: row_uram_arbiter

Interface
REQ-001 Parameter NUM_CORES, default 8, number of cores in a row sharing one URAM port (range 2..16).
REQ-002 Parameter MAX_HOLD_CYCLES, default 4096, maximum cycles a single grant may be held before the error flag is raised.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 i_core_req  input  NUM_CORES  per-core URAM access request (o_core_req of each core).
REQ-006 i_core_locked  input  NUM_CORES  per-core "inside critical section" flag (o_core_locked of each core).
REQ-007 i_active_mask  input  NUM_CORES  cores taking part in the current round; quasi-static, sampled every cycle.
REQ-008 i_drain_done  input  1  single-cycle pulse from the URAM drain engine: URAM contents consumed.
REQ-009 o_core_grant  output  NUM_CORES  one-hot-or-zero grant to each core's i_core_grant.
REQ-010 o_uram_emptied  output  NUM_CORES  per-core i_uram_emptied; all bits always equal.
REQ-011 o_drain_req  output  1  request to the drain engine: every active core has written its share.
REQ-012 o_hold_timeout  output  1  sticky error: a grant exceeded MAX_HOLD_CYCLES.

Function
REQ-013 States: IDLE, GRANT, DRAIN, EMPTIED; all outputs registered.
REQ-014 Eligible set = i_core_req & i_active_mask & ~served, where served is an internal NUM_CORES register.
REQ-015 IDLE: if eligible nonzero, select lowest index >= rr_ptr among eligible, wrapping to 0; set o_core_grant to that bit and go to GRANT; grant is visible the cycle after the request is first sampled (1-cycle latency).
REQ-016 IDLE with eligible zero: stay in IDLE, o_core_grant = 0.
REQ-017 GRANT: exactly one o_core_grant bit high (index g); internal locked_seen sets when i_core_locked[g] = 1.
REQ-018 Session end in GRANT: (locked_seen = 1 and i_core_locked[g] = 0) or (i_core_req[g] = 0 and i_core_locked[g] = 0); on that edge set served[g], set rr_ptr = (g+1) mod NUM_CORES, clear locked_seen and hold counter, drop grant.
REQ-019 After session end: if (served | new bit) covers i_active_mask, go to DRAIN, else go to IDLE; no grant is issued in the same cycle as session end (minimum one idle grant-free cycle between cores).
REQ-020 i_core_req/i_core_locked from non-granted cores are ignored in GRANT.
REQ-021 Hold counter increments each GRANT cycle, saturates at MAX_HOLD_CYCLES; on reaching it, set o_hold_timeout (sticky until reset); grant is NOT revoked.
REQ-022 DRAIN: o_drain_req = 1, no grants; on i_drain_done = 1 go to EMPTIED.
REQ-023 EMPTIED: o_uram_emptied all ones for exactly one cycle, served cleared to 0, o_drain_req = 0; next state IDLE.
REQ-024 i_drain_done outside DRAIN is ignored.
REQ-025 i_active_mask = 0: never enters DRAIN; cores stay ungranted.
REQ-026 A core leaving i_active_mask while granted keeps its grant until its session ends.
REQ-027 rr_ptr width = clog2(NUM_CORES); wrap from NUM_CORES-1 to 0.

Reset
REQ-028 While reset = 0 at a clock edge: state IDLE, served = 0, rr_ptr = 0, locked_seen = 0, counter = 0, all outputs 0 including o_hold_timeout.
REQ-029 Reset asserted mid-GRANT or mid-DRAIN aborts immediately; grant and drain request are low the cycle after the reset edge.

Verification
REQ-030 NUM_CORES=4, mask=1111, req=1111 at once -> grants in order core0,1,2,3, each held until its locked rises and falls, one grant-free cycle between; then o_drain_req=1.
REQ-031 From DRAIN, pulse i_drain_done -> o_uram_emptied=1111 for one cycle, next cycle IDLE with served=0; second round starts at rr_ptr after last served core.
REQ-032 req=0100 only, mask=0101 -> core2 never granted twice; after core2 done, no DRAIN until core0 served; i_drain_done pulsed early is ignored.
REQ-033 MAX_HOLD_CYCLES=16, core1 holds locked 20 cycles -> o_hold_timeout=1 at hold cycle 16, grant stays, flag persists after release.
REQ-034 Assert reset (0) while core3 granted and locked -> next cycle all outputs 0; after release, first request granted from index 0 ordering.
REQ-035 Core drops req without ever locking while granted -> session ends, marked served, grant passes to next eligible core.
